// File: rtl/us_scheduler.sv
// Round-robin trigger/echo scheduler for two ultrasonic rangefinders (left first).
// Times each echo in microseconds and publishes a held distance in mm per sensor.
module us_scheduler #(
  parameter int unsigned CLK_PER_US      = 50,
  parameter int unsigned TRIG_CYCLES     = 500,
  parameter int unsigned RISE_TIMEOUT_US = 2000,
  parameter int unsigned MAX_ECHO_US     = 30000,
  parameter int unsigned GAP_US          = 10000
) (
  input  logic        clk_50M,
  input  logic        reset,
  input  logic        enable,
  input  logic        echo1,
  input  logic        echo2,
  output logic        trig1,
  output logic        trig2,
  output logic [15:0] dist_left,
  output logic [15:0] dist_right,
  output logic        valid_left,
  output logic        valid_right,
  output logic        timeout_left,
  output logic        timeout_right,
  output logic        active_sensor
);

  localparam int unsigned PreW   = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam int unsigned CntMx1 = (GAP_US > RISE_TIMEOUT_US) ? GAP_US : RISE_TIMEOUT_US;
  localparam int unsigned CntMax = (CntMx1 > TRIG_CYCLES) ? CntMx1 : TRIG_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned EchoW  = $clog2(MAX_ECHO_US + 1);

  typedef enum logic [2:0] {StGap, StTrig, StWaitRise, StMeasure, StDone} state_e;

  state_e            state_q, state_d;
  logic [PreW-1:0]   pre_q;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [EchoW-1:0]  echo_us_q, echo_us_d;
  logic              active_q, active_d;
  logic [1:0]        sync1_q, sync2_q;
  logic [15:0]       dist_left_q, dist_right_q;
  logic              valid_left_q, valid_right_q;
  logic              timeout_left_q, timeout_right_q;
  logic              us_tick, echo_sel, fin, fin_fail;
  logic [31:0]       scaled;
  logic [15:0]       dist_new;

  assign us_tick  = (pre_q == PreW'(CLK_PER_US - 1));
  assign echo_sel = active_q ? sync2_q[1] : sync1_q[1];

  // mm = us * 11 / 64, computed wide and saturated
  assign scaled   = (32'(echo_us_q) * 32'd11) >> 6;
  assign dist_new = (fin_fail || (|scaled[31:16])) ? 16'hFFFF : scaled[15:0];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    echo_us_d = echo_us_q;
    active_d  = active_q;
    fin       = 1'b0;
    fin_fail  = 1'b0;
    unique case (state_q)
      StGap: begin
        if (cnt_q == CntW'(GAP_US)) begin
          if (enable) begin
            state_d = StTrig;
            cnt_d   = '0;
          end
        end else if (us_tick) begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StTrig: begin
        if (cnt_q == CntW'(TRIG_CYCLES - 1)) begin
          state_d = StWaitRise;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StWaitRise: begin
        if (echo_sel) begin
          echo_us_d = '0;
          state_d   = StMeasure;
        end else if (us_tick) begin
          if (cnt_q == CntW'(RISE_TIMEOUT_US - 1)) begin
            fin      = 1'b1;
            fin_fail = 1'b1;
            state_d  = StDone;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StMeasure: begin
        if (!echo_sel) begin
          fin     = 1'b1;
          state_d = StDone;
        end else if (us_tick) begin
          echo_us_d = echo_us_q + EchoW'(1);
          if (echo_us_q == EchoW'(MAX_ECHO_US - 1)) begin
            fin      = 1'b1;
            fin_fail = 1'b1;
            state_d  = StDone;
          end
        end
      end
      StDone: begin
        active_d = ~active_q;
        cnt_d    = '0;
        state_d  = StGap;
      end
      default: state_d = StGap;
    endcase
  end

  always_ff @(posedge clk_50M or negedge reset) begin
    if (!reset) begin
      state_q         <= StGap;
      pre_q           <= '0;
      cnt_q           <= '0;
      echo_us_q       <= '0;
      active_q        <= 1'b0;
      sync1_q         <= '0;
      sync2_q         <= '0;
      dist_left_q     <= '0;
      dist_right_q    <= '0;
      valid_left_q    <= 1'b0;
      valid_right_q   <= 1'b0;
      timeout_left_q  <= 1'b0;
      timeout_right_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pre_q     <= us_tick ? '0 : pre_q + PreW'(1);
      cnt_q     <= cnt_d;
      echo_us_q <= echo_us_d;
      active_q  <= active_d;
      sync1_q   <= {sync1_q[0], echo1};
      sync2_q   <= {sync2_q[0], echo2};
      // Result lands on the edge entering DONE so valid and dist change together
      valid_left_q  <= fin && !active_q;
      valid_right_q <= fin && active_q;
      if (fin) begin
        if (active_q) begin
          dist_right_q    <= dist_new;
          timeout_right_q <= fin_fail;
        end else begin
          dist_left_q    <= dist_new;
          timeout_left_q <= fin_fail;
        end
      end
    end
  end

  assign trig1         = (state_q == StTrig) && !active_q;
  assign trig2         = (state_q == StTrig) && active_q;
  assign dist_left     = dist_left_q;
  assign dist_right    = dist_right_q;
  assign valid_left    = valid_left_q;
  assign valid_right   = valid_right_q;
  assign timeout_left  = timeout_left_q;
  assign timeout_right = timeout_right_q;
  assign active_sensor = active_q;

endmodule

// File: tb/tb_us_scheduler.sv
// Self-checking bench for us_scheduler with scaled-down timing parameters.
module tb_us_scheduler;

  localparam int unsigned CPU   = 2;
  localparam int unsigned TRIGC = 6;
  localparam int unsigned RISE  = 40;
  localparam int unsigned MAXE  = 1200;
  localparam int unsigned GAP   = 20;

  logic        clk_50M = 1'b0;
  logic        reset   = 1'b0;
  logic        enable  = 1'b0;
  logic        echo1   = 1'b0;
  logic        echo2   = 1'b0;
  logic        trig1, trig2;
  logic [15:0] dist_left, dist_right;
  logic        valid_left, valid_right;
  logic        timeout_left, timeout_right;
  logic        active_sensor;

  us_scheduler #(
    .CLK_PER_US     (CPU),
    .TRIG_CYCLES    (TRIGC),
    .RISE_TIMEOUT_US(RISE),
    .MAX_ECHO_US    (MAXE),
    .GAP_US         (GAP)
  ) dut (
    .clk_50M      (clk_50M),
    .reset        (reset),
    .enable       (enable),
    .echo1        (echo1),
    .echo2        (echo2),
    .trig1        (trig1),
    .trig2        (trig2),
    .dist_left    (dist_left),
    .dist_right   (dist_right),
    .valid_left   (valid_left),
    .valid_right  (valid_right),
    .timeout_left (timeout_left),
    .timeout_right(timeout_right),
    .active_sensor(active_sensor)
  );

  always #5 clk_50M = ~clk_50M;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    bit sens;       // 0 = left, 1 = right
    int rise_us;    // negative: no echo at all
    int width_us;
    bit tog;        // toggle the other sensor's echo meanwhile
    bit drop_en;    // drop enable shortly after the echo rises
    int exp_dist;
    bit exp_to;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input bit ok, input string name, input int act, input int req);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  // Reference: mm = floor(us * 11 / 64); no echo or over-long echo is out of range
  function automatic int model_dist(input int w, input bit no_echo);
    if (no_echo || w >= int'(MAXE)) return 32'hFFFF;
    return (w * 11) / 64;
  endfunction

  function automatic bit trig_of(input bit s);
    return s ? trig2 : trig1;
  endfunction

  task automatic run_meas(input vec_t v, input string name, output int wait_cyc);
    int  rise, fall, bound, vcnt, ovcnt, tw, other_old, d, dd;
    bit  t, e, o, vs, vo;
    wait_cyc = 0;
    d = -1;
    t = 1'b0;
    while (!trig_of(v.sens) && wait_cyc < 400) begin
      @(negedge clk_50M);
      wait_cyc++;
    end
    check(trig_of(v.sens), {name, " trig seen"}, int'(trig_of(v.sens)), 1);
    if (!trig_of(v.sens)) return;
    check(active_sensor == v.sens, {name, " active_sensor"}, int'(active_sensor), int'(v.sens));
    check(!trig_of(!v.sens), {name, " other trig low"}, int'(trig_of(!v.sens)), 0);
    other_old = v.sens ? int'(dist_left) : int'(dist_right);
    tw = 0;
    while (trig_of(v.sens) && tw < 1000) begin
      @(negedge clk_50M);
      tw++;
    end
    check(tw == int'(TRIGC), {name, " trig width"}, tw, TRIGC);
    rise  = (v.rise_us < 0) ? -1 : v.rise_us * int'(CPU);
    fall  = (v.rise_us < 0) ? 0 : (v.rise_us + v.width_us) * int'(CPU);
    bound = fall + int'((RISE + 10) * CPU) + 100;
    vcnt  = 0;
    ovcnt = 0;
    for (int c = 0; c < bound; c++) begin
      e = (rise >= 0) && (c >= rise) && (c < fall);
      o = v.tog && c[2];
      if (v.sens) begin echo2 = e; echo1 = o; end
      else begin echo1 = e; echo2 = o; end
      if (v.drop_en && c == rise + 10) enable = 1'b0;
      @(negedge clk_50M);
      vs = v.sens ? valid_right : valid_left;
      vo = v.sens ? valid_left : valid_right;
      if (vs) begin
        if (vcnt == 0) begin
          d = v.sens ? int'(dist_right) : int'(dist_left);
          t = v.sens ? timeout_right : timeout_left;
        end
        vcnt++;
      end
      if (vo) ovcnt++;
      if (vcnt > 0 && c >= fall && !vs) break;
    end
    echo1 = 1'b0;
    echo2 = 1'b0;
    check(vcnt == 1, {name, " valid pulse width"}, vcnt, 1);
    check(ovcnt == 0, {name, " no other valid"}, ovcnt, 0);
    if (v.exp_dist == 32'hFFFF) begin
      check(d == 32'hFFFF, {name, " dist out of range"}, d, v.exp_dist);
    end else begin
      dd = d - v.exp_dist;
      check(d != 32'hFFFF && dd >= -1 && dd <= 1, {name, " dist"}, d, v.exp_dist);
    end
    check(t == v.exp_to, {name, " timeout flag"}, int'(t), int'(v.exp_to));
    check((v.sens ? int'(dist_left) : int'(dist_right)) == other_old, {name, " other dist held"},
          v.sens ? int'(dist_left) : int'(dist_right), other_old);
  endtask

  task automatic check_reset_outputs(input string name);
    check(!trig1 && !trig2, {name, " triggers low"}, int'({trig1, trig2}), 0);
    check(dist_left == 16'd0 && dist_right == 16'd0, {name, " dists zero"},
          int'(dist_left) + int'(dist_right), 0);
    check(!valid_left && !valid_right, {name, " valids low"}, int'({valid_left, valid_right}), 0);
    check(!timeout_left && !timeout_right, {name, " timeouts low"},
          int'({timeout_left, timeout_right}), 0);
    check(!active_sensor, {name, " active left"}, int'(active_sensor), 0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   wc, any_trig, w, r;
    bit   ne;
    vec_t v;

    //           sens rise width tog drop  dist     to
    tbl[0] = '{1'b0, -1,    0, 1'b0, 1'b0, 'hFFFF, 1'b1};
    tbl[1] = '{1'b1, -1,    0, 1'b0, 1'b0, 'hFFFF, 1'b1};
    tbl[2] = '{1'b0, 20, 1000, 1'b1, 1'b0, 171,    1'b0};
    tbl[3] = '{1'b1,  5,  580, 1'b0, 1'b0, 99,     1'b0};
    tbl[4] = '{1'b0,  0,  100, 1'b0, 1'b0, 17,     1'b0};
    tbl[5] = '{1'b1,  3, 1210, 1'b0, 1'b0, 'hFFFF, 1'b1};
    tbl[6] = '{1'b0, 10,    5, 1'b1, 1'b0, 0,      1'b0};
    tbl[7] = '{1'b1,  8, 1100, 1'b1, 1'b0, 189,    1'b0};
    tbl[8] = '{1'b0,  2,  700, 1'b0, 1'b1, 120,    1'b0};

    enable = 1'b1;
    repeat (3) @(negedge clk_50M);
    check_reset_outputs("reset");
    reset = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_meas(tbl[i], $sformatf("vec%0d", i), wc);
      if (i == 0)
        check(wc >= int'(GAP * CPU - CPU) && wc <= int'(GAP * CPU + CPU + 4), "first trig delay",
              wc, GAP * CPU);
    end

    // Enable dropped during the last measurement: scheduler parks in GAP
    any_trig = 0;
    repeat (300) begin
      @(negedge clk_50M);
      if (trig1 || trig2) any_trig++;
    end
    check(any_trig == 0, "parked no trig", any_trig, 0);
    check(active_sensor == 1'b1, "parked next right", int'(active_sensor), 1);
    enable = 1'b1;
    v = '{1'b1, 4, 300, 1'b0, 1'b0, 51, 1'b0};
    run_meas(v, "reenable", wc);
    check(wc <= 3, "reenable trig immediate", wc, 1);

    for (int i = 0; i < 12; i++) begin
      w  = int'($urandom_range(1, 1150));
      r  = int'($urandom_range(0, 25));
      ne = ($urandom_range(0, 5) == 0);
      v.sens     = i[0];
      v.rise_us  = ne ? -1 : r;
      v.width_us = w;
      v.tog      = 1'($urandom_range(0, 1));
      v.drop_en  = 1'b0;
      v.exp_dist = model_dist(w, ne);
      v.exp_to   = (v.exp_dist == 32'hFFFF);
      run_meas(v, $sformatf("rand%0d", i), wc);
    end

    // Asynchronous reset in the middle of a trigger pulse
    wc = 0;
    while (!(trig1 || trig2) && wc < 400) begin
      @(negedge clk_50M);
      wc++;
    end
    check(trig1 || trig2, "pre-reset trig seen", int'({trig1, trig2}), 1);
    @(negedge clk_50M);
    #2 reset = 1'b0;
    #1 check_reset_outputs("async reset");
    repeat (3) @(negedge clk_50M);
    reset = 1'b1;
    v = '{1'b0, 3, 50, 1'b0, 1'b0, 8, 1'b0};
    run_meas(v, "post-reset", wc);
    check(wc >= int'(GAP * CPU - CPU) && wc <= int'(GAP * CPU + CPU + 4), "post-reset trig delay",
          wc, GAP * CPU);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/us_scheduler.md
# us_scheduler

Round-robin scheduler for the two ultrasonic rangefinders on the robot. It fires one sensor at a time (left, then right) so that crosstalk is avoided. For each sensor it times the echo pulse, converts the width to millimetres and publishes a held distance per sensor for the motor driver. It replaces free-running per-sensor triggering and sits between the sensor pins and the `dist_left`/`dist_right` consumers, all on the 50 MHz domain.

## Interface
Parameters:
- `CLK_PER_US`, 50: clk cycles per microsecond tick.
- `TRIG_CYCLES`, 500: trigger pulse width in clk cycles (10 µs).
- `RISE_TIMEOUT_US`, 2000: maximum wait for the echo rising edge after the trigger ends.
- `MAX_ECHO_US`, 30000: maximum echo high time before the measurement is declared out of range.
- `GAP_US`, 10000: hold-off between the end of one measurement and the next trigger.

Ports:
- `clk_50M`, input, 1: system clock.
- `reset`, input, 1: asynchronous, active-low reset.
- `enable`, input, 1: run the scheduler. When low, the block parks in GAP after the current measurement completes.
- `echo1`, input, 1: left sensor echo. Asynchronous; 2-flop synchronised inside the block.
- `echo2`, input, 1: right sensor echo. Asynchronous; 2-flop synchronised inside the block.
- `trig1`, output, 1: left sensor trigger.
- `trig2`, output, 1: right sensor trigger.
- `dist_left`, output, 16: last left distance in mm. 16'hFFFF means out of range.
- `dist_right`, output, 16: last right distance in mm. 16'hFFFF means out of range.
- `valid_left`, output, 1: one-cycle strobe when `dist_left` updates.
- `valid_right`, output, 1: one-cycle strobe when `dist_right` updates.
- `timeout_left`, output, 1: sticky flag; the last left measurement failed.
- `timeout_right`, output, 1: sticky flag; the last right measurement failed.
- `active_sensor`, output, 1: sensor currently being serviced (0 = left, 1 = right).

## Operation
- Microsecond tick: a free-running prescaler counts 0..CLK_PER_US-1 and pulses `us_tick` on wrap. All `_US` counts advance only on `us_tick`.
- State machine: GAP → TRIG → WAIT_RISE → MEASURE → DONE → GAP.
  - GAP: count `GAP_US` ticks. At the end, if `enable` is high go to TRIG; otherwise hold with the counter saturated.
  - TRIG: drive the trigger of `active_sensor` high for exactly `TRIG_CYCLES` clk cycles, then go to WAIT_RISE. The other trigger is always low.
  - WAIT_RISE: on synchronised echo = 1, clear `echo_us` and go to MEASURE. After `RISE_TIMEOUT_US` ticks with no rise, record a timeout and go to DONE.
  - MEASURE: increment `echo_us` on each tick while echo is high. On echo = 0, record a success and go to DONE. When `echo_us` reaches `MAX_ECHO_US`, record a timeout and go to DONE without waiting for the echo to fall.
  - DONE (1 cycle): update the selected sensor's registers, toggle `active_sensor`, go to GAP.
- Success: dist = (`echo_us` × 11) >> 6, which is about µs/5.82. Compute at ≥19-bit width and saturate to 16 bits. Clear the sensor's timeout flag.
- Timeout: dist = 16'hFFFF and set the sensor's timeout flag.
- In both cases, pulse the sensor's `valid_*` in the DONE cycle; the `dist_*` register changes on the same edge.
- An echo already high on entry to WAIT_RISE counts as a rise; measurement starts on the first cycle.
- Echo activity on the non-selected sensor is ignored.
- Dropping `enable` mid-measurement does not abort; the cycle completes and publishes normally.

## Timing
- Reset values: state GAP, `active_sensor` 0, both triggers 0, both distances 0, valids 0, timeout flags 0, all counters 0.
- First `trig1` rises `GAP_US` µs (±1 tick) after reset release with `enable` high.
- Echo-to-state latency is 2 clk cycles (synchroniser).
- Width quantisation is ±1 µs because the tick is free-running.
- `valid_*` asserts 1 clk after the synchronised echo falls, or 1 clk after a timeout is detected.
- Full cycle per sensor = GAP + 10 µs + rise delay + echo width. The two sensors alternate strictly, left first.
- Asynchronous reset mid-operation immediately drops both triggers and clears all outputs.

## Test plan
- Reset release, `enable` = 1, no echoes → `trig1` high 500 cycles starting ~10 ms after reset; `timeout_left` = 1 and `dist_left` = 16'hFFFF 2 ms later; next `trig2` follows 10 ms after that.
- Left echo rises 400 µs after trigger, high 5830 µs → `dist_left` = 1002 ±1; `valid_left` one cycle; `timeout_left` cleared; `dist_right` unchanged.
- Right echo high 580 µs → `dist_right` = 99 ±1; then echo held high for 40 ms → 30000 µs cutoff gives `dist_right` = 16'hFFFF and `timeout_right` = 1.
- Toggle `echo2` throughout the left measurement → only `echo1` affects `dist_left`; no `valid_right` pulse.
- Drop `enable` during MEASURE → current result is published, then both triggers stay low indefinitely; raising `enable` again → next trigger issues immediately on the other sensor.
- Assert `reset` during TRIG → trigger drops within the same cycle; after release, behaviour matches a fresh start with the left sensor first.
